// File: rtl/uart_operand_pkg.sv
// Shared types and constants for the UART operand port: controller and
// receiver state encodings, frame layout and baud divider helpers.
package uart_operand_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    READY   = 2'd1,
    SEND    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  function automatic int unsigned calc_sample_div(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned ratio);
    return clk_hz / baud / ratio;
  endfunction

  function automatic int unsigned calc_bit_div(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned ratio);
    return calc_sample_div(clk_hz, baud, ratio) * ratio;
  endfunction

endpackage

// File: rtl/uart_operand_port_rx_byte.sv
// Oversampling UART byte receiver: 2-flop synchroniser, mid-bit start
// qualification, LSB-first data capture and stop-bit framing check.
module uart_rx_byte
  import uart_operand_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 651,
  parameter int unsigned SAMPLE_RATIO = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [31:0] div_q, div_d;
  logic [7:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        tick;

  assign tick       = (div_q == 32'(SAMPLE_DIV - 1));
  assign byte_valid = valid_q;
  assign rx_byte    = data_q;
  assign frame_err  = ferr_q;

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 32'd1;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        div_d  = '0;
        tick_d = '0;
        bit_d  = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (tick) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else if (tick_q == 8'(SAMPLE_RATIO / 2 - 1)) begin
            tick_d  = '0;
            state_d = RX_DATA;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tick_q == 8'(SAMPLE_RATIO - 1)) begin
            tick_d = '0;
            data_d = {sync2_q, data_q[7:1]};
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tick_q == 8'(SAMPLE_RATIO - 1)) begin
            tick_d = '0;
            if (sync2_q) begin
              valid_d = 1'b1;
              state_d = RX_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = RX_BREAK;
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      // A low stop bit means the line may still be low; wait for idle before re-arming.
      RX_BREAK: begin
        div_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= din;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_operand_port.sv
// UART operand port: collects an operand set from received bytes, then
// transmits a result back as back-to-back frames on request.
module uart_operand_port
  import uart_operand_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned SAMPLE_RATIO  = 16,
  parameter int unsigned OPERAND_WIDTH = 16,
  parameter int unsigned OPERAND_COUNT = 2,
  parameter int unsigned RESULT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_BITS  = 32
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   din,
  output logic                                   dout,
  output logic [OPERAND_COUNT*OPERAND_WIDTH-1:0] operands,
  output logic                                   ready,
  input  logic [RESULT_WIDTH-1:0]                result,
  input  logic                                   tx_en,
  output logic                                   busy,
  output logic                                   frame_err,
  output logic                                   timeout_err
);

  localparam int unsigned SAMPLE_DIV = calc_sample_div(CLK_FREQUENCY, BAUD_RATE, SAMPLE_RATIO);
  localparam int unsigned BIT_DIV    = calc_bit_div(CLK_FREQUENCY, BAUD_RATE, SAMPLE_RATIO);
  localparam int unsigned OP_W       = OPERAND_COUNT * OPERAND_WIDTH;
  localparam int unsigned N_BYTES    = OP_W / 8;
  localparam int unsigned TX_BYTES   = RESULT_WIDTH / 8;
  localparam int unsigned TO_LIMIT   = TIMEOUT_BITS * BIT_DIV;

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [OP_W-1:0]         shadow_q, shadow_d, shadow_ins;
  logic [OP_W-1:0]         operands_q, operands_d;
  logic [31:0]             to_cnt_q, to_cnt_d;
  logic                    to_err_q, to_err_d;
  logic [RESULT_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [31:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]              bit_idx_q, bit_idx_d;
  logic [1:0]              tx_byte_q, tx_byte_d;
  logic [FRAME_BITS-1:0]   tx_frame;
  logic                    rx_valid, rx_ferr;
  logic [7:0]              rx_data;

  uart_rx_byte #(
    .SAMPLE_DIV  (SAMPLE_DIV),
    .SAMPLE_RATIO(SAMPLE_RATIO)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .byte_valid(rx_valid),
    .rx_byte   (rx_data),
    .frame_err (rx_ferr)
  );

  assign tx_frame    = {1'b1, tx_shift_q[7:0], 1'b0};
  assign dout        = (state_q == SEND) ? tx_frame[bit_idx_q] : 1'b1;
  assign operands    = operands_q;
  assign ready       = (state_q == READY);
  assign busy        = (state_q == SEND);
  assign frame_err   = rx_ferr;
  assign timeout_err = to_err_q;

  always_comb begin
    shadow_ins = shadow_q;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      if (idx_q == 4'(i)) shadow_ins[i*8 +: 8] = rx_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    operands_d = operands_q;
    to_cnt_d   = to_cnt_q;
    to_err_d   = 1'b0;
    tx_shift_d = tx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    tx_byte_d  = tx_byte_q;
    unique case (state_q)
      // A good byte takes priority over a timeout expiring in the same cycle.
      COLLECT: begin
        if (rx_valid) begin
          to_cnt_d = '0;
          if (idx_q == 4'(N_BYTES - 1)) begin
            operands_d = shadow_ins;
            shadow_d   = '0;
            idx_d      = '0;
            state_d    = READY;
          end else begin
            shadow_d = shadow_ins;
            idx_d    = idx_q + 4'd1;
          end
        end else if (rx_ferr) begin
          shadow_d = '0;
          idx_d    = '0;
          to_cnt_d = '0;
        end else if (TIMEOUT_BITS != 0 && idx_q != '0) begin
          if (to_cnt_q == 32'(TO_LIMIT - 1)) begin
            to_err_d = 1'b1;
            shadow_d = '0;
            idx_d    = '0;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 32'd1;
          end
        end
      end
      READY: begin
        if (tx_en) begin
          tx_shift_d = result;
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          tx_byte_d  = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bit_cnt_q == 32'(BIT_DIV - 1)) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
            bit_idx_d  = '0;
            tx_byte_d  = tx_byte_q + 2'd1;
            tx_shift_d = tx_shift_q >> 8;
            if (tx_byte_q == 2'(TX_BYTES - 1)) begin
              idx_d   = '0;
              state_d = COLLECT;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 32'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= COLLECT;
      idx_q      <= '0;
      shadow_q   <= '0;
      operands_q <= '0;
      to_cnt_q   <= '0;
      to_err_q   <= 1'b0;
      tx_shift_q <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      operands_q <= operands_d;
      to_cnt_q   <= to_cnt_d;
      to_err_q   <= to_err_d;
      tx_shift_q <= tx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_uart_operand_port.sv
// Directed bench for uart_operand_port: a transaction-level model predicts
// ready/operands/busy/dout each cycle, plus literal checks at key points.
module tb_uart_operand_port;

  localparam int BITC = 160;
  localparam int SEND_CYC = 2 * 10 * BITC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        din = 1'b1;
  logic        tx_en = 1'b0;
  logic [15:0] result = '0;
  logic        dout, ready, busy, frame_err, timeout_err;
  logic [31:0] operands;

  uart_operand_port #(
    .CLK_FREQUENCY(1_600_000),
    .BAUD_RATE    (10_000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .dout       (dout),
    .operands   (operands),
    .ready      (ready),
    .result     (result),
    .tx_en      (tx_en),
    .busy       (busy),
    .frame_err  (frame_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m_operands = '0;
  logic [15:0] m_result = '0;
  logic [7:0]  m_bytes[4];
  bit          m_ready = 1'b0;
  bit          m_settle = 1'b0;
  bit          m_tx_active = 1'b0;
  int          m_tx_start = 0;
  int          m_idx = 0;
  bit          chk_en = 1'b0;
  int          fe_cycles = 0;
  int          to_cycles = 0;
  int          busy_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Line level of a 2-frame UART transmission 'off' clocks after it starts.
  function automatic logic model_dout(input int off, input logic [15:0] r);
    logic [15:0] rs;
    int bi;
    if (off < 0 || off >= SEND_CYC) return 1'b1;
    rs = r >> (8 * (off / (10 * BITC)));
    bi = (off % (10 * BITC)) / BITC;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return rs[bi-1];
  endfunction

  always @(negedge clk) begin
    int off;
    if (chk_en && reset_n) begin
      off = m_tx_active ? cyc - m_tx_start : -1;
      check("busy", {31'd0, busy}, {31'd0, (off >= 0 && off < SEND_CYC)});
      check("dout", {31'd0, dout}, {31'd0, model_dout(off, m_result)});
      if (!m_settle) begin
        check("ready", {31'd0, ready}, {31'd0, m_ready});
        check("operands", operands, m_operands);
      end
      if (frame_err) fe_cycles++;
      if (timeout_err) to_cycles++;
      if (busy) busy_cycles++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bit collecting;
    collecting = !m_ready && !m_tx_active;
    din = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      tick(BITC);
    end
    if (collecting && stop_ok && m_idx == 3) m_settle = 1'b1;
    din = stop_ok;
    tick(BITC);
    if (collecting) begin
      if (stop_ok) begin
        m_bytes[m_idx] = b;
        m_idx++;
        if (m_idx == 4) begin
          m_operands = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_ready = 1'b1;
          m_idx = 0;
        end
      end else begin
        m_idx = 0;
      end
    end
    m_settle = 1'b0;
    din = 1'b1;
    tick(BITC);
  endtask

  task automatic send_set(input logic [31:0] v);
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], 1'b1);
  endtask

  task automatic tx_pulse(input logic [15:0] r);
    result = r;
    tx_en = 1'b1;
    tick(1);
    tx_en = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_tx_active = 1'b1;
      m_tx_start = cyc;
      m_result = r;
    end
  endtask

  task automatic wait_send_done();
    while (cyc - m_tx_start < SEND_CYC + 10) tick(1);
    m_tx_active = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_dout", {31'd0, dout}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_operands", operands, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    reset_n = 1'b1;
    tick(5);
    chk_en = 1'b1;
    tick(200);

    // First operand set
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    check("set1_operands", operands, 32'h5678_1234);
    check("set1_ready", {31'd0, ready}, 32'd1);

    // Transmit 0xBEEF
    busy_cycles = 0;
    tx_pulse(16'hBEEF);
    tick(80);
    check("tx_start0", {31'd0, dout}, 32'd0);
    check("tx_ready_low", {31'd0, ready}, 32'd0);
    tick(160);
    check("tx_ef_bit0", {31'd0, dout}, 32'd1);
    tick(1440);
    check("tx_start1", {31'd0, dout}, 32'd0);
    tick(160);
    check("tx_be_bit0", {31'd0, dout}, 32'd0);
    tick(640);
    check("tx_be_bit4", {31'd0, dout}, 32'd1);
    wait_send_done();
    check("tx_busy_len", busy_cycles, 32'd3200);
    check("tx_done_busy", {31'd0, busy}, 32'd0);

    // Frame error mid-set, then a full set
    send_byte(8'h34, 1'b1);
    send_byte(8'h11, 1'b0);
    check("fe_pulse", fe_cycles, 32'd1);
    check("fe_operands", operands, 32'h5678_1234);
    send_set(32'h0403_0201);
    check("set2_operands", operands, 32'h0403_0201);

    // Bytes during SEND are ignored; tx_en in COLLECT is ignored
    tx_pulse(16'h1234);
    send_byte(8'h99, 1'b1);
    wait_send_done();
    tx_pulse(16'hFFFF);
    tick(300);
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_dout", {31'd0, dout}, 32'd1);
    send_set(32'h4433_2211);
    check("set3_operands", operands, 32'h4433_2211);
    tx_pulse(16'hA55A);
    wait_send_done();

    // Timeout after a partial set
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    tick(4700);
    check("to_not_early", to_cycles, 32'd0);
    tick(400);
    check("to_pulse", to_cycles, 32'd1);
    m_idx = 0;
    send_set(32'h8877_6655);
    check("set4_operands", operands, 32'h8877_6655);
    check("fe_total", fe_cycles, 32'd1);

    // Reset in the middle of the second frame
    tx_pulse(16'hC0DE);
    tick(2100);
    chk_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_dout", {31'd0, dout}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_operands", operands, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    m_ready = 1'b0;
    m_tx_active = 1'b0;
    m_operands = '0;
    m_idx = 0;
    m_settle = 1'b0;
    tick(5);
    reset_n = 1'b1;
    tick(5);
    chk_en = 1'b1;
    tick(400);
    check("post_rst_dout", {31'd0, dout}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
